fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_pc_reg.sv | 41 ++++
 rtl/fetch_controller.sv | 153 +++++++++++++++
 tb/tb_fetch_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch
// controller and its PC register.
package fetch_pkg;

    // Controller states: issue a request, wait for its response, present the
    // instruction to decode, or swallow the response of an abandoned request.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // Sequential fetch stride in bytes.
    localparam int PC_INCR = 4;

    // Default PC loaded on reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter register. A load (redirect) takes priority
// over a sequential increment; the increment wraps modulo 2^ADDR_W.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;

    // Next PC: redirect first, then sequential step, otherwise hold.
    always_comb begin
        pc_next = pc_reg;
        if (load) begin
            pc_next = load_addr;
        end else if (incr) begin
            pc_next = pc_reg + ADDR_W'(PC_INCR);
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding-request instruction fetch unit.
// Issues one memory request, waits for the response, holds the instruction
// until decode accepts it, and handles redirects in every state.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned redirects are
// rejected and flagged on misalign_trap; otherwise the low target bits are
// cleared and misalign_trap stays low.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              misalign_trap
);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic              pc_load;
    logic              pc_incr;
    logic              capture;
    logic              branch_take;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] out_instr_reg;
    logic [ADDR_W-1:0] out_pc_reg;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    logic trap_reg;

    // A redirect to a non-word-aligned target is refused outright.
    assign misaligned  = |branch_target[1:0];
    assign branch_take = branch_en && !misaligned;
    assign load_addr   = branch_target;

    // One trap pulse per refused redirect request.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_reg <= 1'b0;
        end else begin
            trap_reg <= branch_en && misaligned;
        end
    end

    assign misalign_trap = trap_reg && !reset;
`else
    // Redirects are always taken; the target is forced onto a word boundary.
    assign branch_take   = branch_en;
    assign load_addr     = branch_target & ~ADDR_W'(3);
    assign misalign_trap = 1'b0;
`endif

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (pc_load),
        .load_addr (load_addr),
        .incr      (pc_incr),
        .pc        (pc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and PC control. A redirect always wins; a request accepted in
    // the same cycle as a redirect is orphaned and its response must be dropped.
    always_comb begin
        state_next = state_reg;
        pc_load    = 1'b0;
        pc_incr    = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            FETCH: begin
                if (branch_take) begin
                    pc_load    = 1'b1;
                    state_next = imem_req_ready ? DROP : FETCH;
                end else if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (branch_take) begin
                    pc_load    = 1'b1;
                    state_next = imem_rsp_valid ? FETCH : DROP;
                end else if (imem_rsp_valid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (branch_take) begin
                    pc_load    = 1'b1;
                    state_next = FETCH;
                end else if (out_ready) begin
                    pc_incr    = 1'b1;
                    state_next = FETCH;
                end
            end
            DROP: begin
                if (branch_take) begin
                    pc_load = 1'b1;
                end
                if (imem_rsp_valid) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Capture the fetched instruction together with the address it came from.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_instr_reg <= '0;
            out_pc_reg    <= '0;
        end else if (capture) begin
            out_instr_reg <= imem_rsp_data;
            out_pc_reg    <= pc;
        end
    end

    assign imem_req_valid = (state_reg == FETCH) && !reset;
    assign imem_req_addr  = pc;
    assign out_valid      = (state_reg == HOLD) && !reset;
    assign out_instr      = out_instr_reg;
    assign out_pc         = out_pc_reg;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: scoreboard bench for fetch_controller. Expected request
// addresses and decoded instructions are queued as each scenario is set up and
// popped as the DUT issues requests and hands instructions to decode.
// Honours FETCH_ALIGN_CHECK_EN the same way as the design.
`timescale 1ns/1ps
module tb_fetch_controller;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        branch_en = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_trap;

    logic [31:0] exp_req_q[$];
    out_exp_t    exp_out_q[$];
    int          acc_cyc[$];
    int          hs_cyc[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cycle = 0;
    bit          kill_hs = 1'b0;
    bit          last_acc = 1'b0;
    bit          rsp_pending = 1'b0;
    int          rsp_cnt = 0;
    int          rsp_lat = 1;
    logic [31:0] rsp_addr = '0;

    fetch_controller #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .branch_en      (branch_en),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_trap  (misalign_trap)
    );

    always #5 clk = ~clk;

    // Contents of the instruction memory model.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] addr, input bit deliver);
        out_exp_t e;
        exp_req_q.push_back(addr);
        if (deliver) begin
            e.pc    = addr;
            e.instr = mem_word(addr);
            exp_out_q.push_back(e);
        end
    endtask

    // One clock: score the handshakes of the current cycle, advance, then
    // drive the memory response for the new cycle.
    task automatic tick();
        logic [31:0] want;
        out_exp_t    e;
        bit          acc;
        bit          hs;
        #1;
        acc = imem_req_valid && imem_req_ready;
        hs  = out_valid && out_ready && !kill_hs;
        if (acc) begin
            $display("cycle %0d: request addr=%h", cycle, imem_req_addr);
            check_val("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
            if (exp_req_q.size() != 0) begin
                want = exp_req_q.pop_front();
                check_val("req_addr", imem_req_addr, want);
            end
            acc_cyc.push_back(cycle);
            rsp_pending = 1'b1;
            rsp_cnt     = rsp_lat;
            rsp_addr    = imem_req_addr;
        end
        if (hs) begin
            $display("cycle %0d: decode pc=%h instr=%h", cycle, out_pc, out_instr);
            check_val("out_expected", 32'(exp_out_q.size() != 0), 32'd1);
            if (exp_out_q.size() != 0) begin
                e = exp_out_q.pop_front();
                check_val("out_pc", out_pc, e.pc);
                check_val("out_instr", out_instr, e.instr);
            end
            hs_cyc.push_back(cycle);
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        cycle++;
        imem_rsp_valid = 1'b0;
        if (rsp_pending) begin
            rsp_cnt--;
            if (rsp_cnt <= 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(rsp_addr);
                rsp_pending    = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        branch_en      = 1'b0;
        kill_hs        = 1'b0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        rsp_pending    = 1'b0;
        rsp_lat        = 1;
        exp_req_q.delete();
        exp_out_q.delete();
        acc_cyc.delete();
        hs_cyc.delete();
        tick();
        check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_trap", 32'(misalign_trap), 32'd0);
        check_val("rst_out_instr", out_instr, 32'd0);
        check_val("rst_out_pc", out_pc, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_req_q.size() == 0 && exp_out_q.size() == 0) break;
            tick();
        end
        check_val("drain_req", 32'(exp_req_q.size()), 32'd0);
        check_val("drain_out", 32'(exp_out_q.size()), 32'd0);
    endtask

    task automatic wait_out_empty(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_out_q.size() == 0) break;
            tick();
        end
        check_val("out_empty", 32'(exp_out_q.size()), 32'd0);
    endtask

    task automatic wait_for_accept(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < budget);
        check_val("accept_wait", 32'(last_acc), 32'd1);
    endtask

    task automatic wait_for_hold(input int budget);
        for (int i = 0; i < budget; i++) begin
            #1;
            if (out_valid) break;
            tick();
        end
        check_val("hold_wait", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential fetch: 0x0, 0x4, 0x8 three cycles apart, 2-cycle latency.
        do_reset();
        out_ready = 1'b1;
        expect_fetch(32'h0, 1'b1);
        expect_fetch(32'h4, 1'b1);
        expect_fetch(32'h8, 1'b1);
        wait_drain(60);
        check_val("gap_0_4", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check_val("gap_4_8", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        check_val("latency", 32'(hs_cyc[0] - acc_cyc[0]), 32'd2);

        // Decode stall: instruction held stable, no new request, then pc=0x4.
        do_reset();
        expect_fetch(32'h0, 1'b1);
        wait_for_hold(20);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("stall_valid", 32'(out_valid), 32'd1);
            check_val("stall_instr", out_instr, mem_word(32'h0));
            check_val("stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        expect_fetch(32'h4, 1'b1);
        out_ready = 1'b1;
        wait_drain(40);

        // Redirect in WAIT, stale response two cycles later is dropped.
        do_reset();
        out_ready = 1'b1;
        rsp_lat = 3;
        expect_fetch(32'h0, 1'b0);
        wait_for_accept(20);
        branch_en = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_en = 1'b0;
        check_val("drop_no_req", 32'(imem_req_valid), 32'd0);
        rsp_lat = 1;
        expect_fetch(32'h100, 1'b1);
        wait_drain(40);

        // Second redirect while dropping replaces the target.
        do_reset();
        out_ready = 1'b1;
        rsp_lat = 3;
        expect_fetch(32'h0, 1'b0);
        wait_for_accept(20);
        branch_en = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_target = 32'h180;
        tick();
        branch_en = 1'b0;
        rsp_lat = 1;
        expect_fetch(32'h180, 1'b1);
        wait_drain(40);

        // Redirect coincident with decode accept at pc=0x8: no +4.
        do_reset();
        out_ready = 1'b1;
        expect_fetch(32'h0, 1'b1);
        expect_fetch(32'h4, 1'b1);
        expect_fetch(32'h8, 1'b0);
        wait_out_empty(40);
        wait_for_hold(20);
        check_val("hold_pc8", out_pc, 32'h8);
        branch_en = 1'b1;
        branch_target = 32'h200;
        kill_hs = 1'b1;
        expect_fetch(32'h200, 1'b1);
        tick();
        branch_en = 1'b0;
        kill_hs = 1'b0;
        check_val("branch_clears_valid", 32'(out_valid), 32'd0);
        wait_drain(40);

        // Redirect coincident with a response in WAIT discards it.
        do_reset();
        out_ready = 1'b1;
        rsp_lat = 2;
        expect_fetch(32'h0, 1'b0);
        wait_for_accept(20);
        tick();
        branch_en = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_en = 1'b0;
        check_val("rsp_discard_valid", 32'(out_valid), 32'd0);
        rsp_lat = 1;
        expect_fetch(32'h40, 1'b1);
        wait_drain(40);

        // Redirect in FETCH while memory stalls, then wrap 0xFFFF_FFFC -> 0.
        do_reset();
        out_ready = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        check_val("stall_req_valid", 32'(imem_req_valid), 32'd1);
        check_val("stall_req_addr", imem_req_addr, 32'h0);
        branch_en = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_en = 1'b0;
        check_val("redirect_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        expect_fetch(32'hFFFF_FFFC, 1'b1);
        expect_fetch(32'h0, 1'b1);
        wait_drain(40);

        // Misaligned redirect to 0x102 in HOLD with decode accepting.
        do_reset();
        out_ready = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        expect_fetch(32'h0, 1'b1);
`else
        expect_fetch(32'h0, 1'b0);
`endif
        wait_for_hold(20);
        branch_en = 1'b1;
        branch_target = 32'h102;
`ifdef FETCH_ALIGN_CHECK_EN
        expect_fetch(32'h4, 1'b1);
`else
        kill_hs = 1'b1;
        expect_fetch(32'h100, 1'b1);
`endif
        tick();
        branch_en = 1'b0;
        kill_hs = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check_val("trap_pulse", 32'(misalign_trap), 32'd1);
`else
        check_val("trap_tied", 32'(misalign_trap), 32'd0);
`endif
        tick();
        check_val("trap_low", 32'(misalign_trap), 32'd0);
        wait_drain(40);

        // Reset mid-transaction; stale response arriving in FETCH is ignored.
        do_reset();
        out_ready = 1'b1;
        rsp_lat = 3;
        expect_fetch(32'h0, 1'b0);
        wait_for_accept(20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        tick();
        check_val("stale_ignored", 32'(out_valid), 32'd0);
        check_val("stale_req_valid", 32'(imem_req_valid), 32'd1);
        check_val("stale_req_addr", imem_req_addr, 32'h0);
        imem_req_ready = 1'b1;
        rsp_lat = 1;
        expect_fetch(32'h0, 1'b1);
        wait_drain(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
